nes_poll_sequencer: RTL and testbench

- Polls two NES gamepads that share one latch line and one clock line; each pad has its own serial data line.
- Deserialises each pad's 8 buttons into stable active-high vectors.
- Converts button changes into a single arbitrated press/release event stream with a valid/ready handshake, consumed by the game FSM.

---
 rtl/nes_pkg.sv | 36 +++
 rtl/nes_event_arbiter.sv | 60 ++++++
 rtl/nes_poll_sequencer.sv | 126 ++++++++++++
 tb/tb_nes_poll_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types for the NES pad poller: button indices, poll FSM states and
// the press/release event payload.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    COMMIT
  } poll_state_t;

  typedef struct packed {
    logic       pad;
    logic [2:0] code;
    logic       press;
  } nes_evt_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = BTN_RIGHT; i >= BTN_A; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/nes_event_arbiter.sv
// Turns differences between the live button vectors and the last state handed
// to the consumer into a single prioritised press/release event stream.
module nes_event_arbiter
  import nes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons0,
  input  logic [7:0] buttons1,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_pad,
  output logic [2:0] evt_code,
  output logic       evt_press
);

  logic [7:0] reported0;
  logic [7:0] reported1;
  logic [7:0] pending0;
  logic [7:0] pending1;
  nes_evt_t   win;
  nes_evt_t   evt_q;

  assign pending0 = buttons0 ^ reported0;
  assign pending1 = buttons1 ^ reported1;

  // Pad 0 outranks pad 1; within a pad the lowest button index wins.
  always_comb begin
    win       = '0;
    win.pad   = (pending0 == 8'd0);
    win.code  = win.pad ? lowest_set(pending1) : lowest_set(pending0);
    win.press = win.pad ? buttons1[win.code] : buttons0[win.code];
  end

  // Handshake: an event transfers on a cycle with evt_valid & evt_ready; the
  // payload is frozen while evt_valid is high, and evt_valid drops for at
  // least one cycle after each transfer before the next event is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reported0 <= 8'd0;
      reported1 <= 8'd0;
      evt_q     <= '0;
      evt_valid <= 1'b0;
    end else if (evt_valid) begin
      if (evt_ready) begin
        evt_valid <= 1'b0;
        if (evt_q.pad) reported1[evt_q.code] <= evt_q.press;
        else           reported0[evt_q.code] <= evt_q.press;
      end
    end else if ((pending0 | pending1) != 8'd0) begin
      evt_valid <= 1'b1;
      evt_q     <= win;
    end
  end

  assign evt_pad   = evt_q.pad;
  assign evt_code  = evt_q.code;
  assign evt_press = evt_q.press;

endmodule

// File: rtl/nes_poll_sequencer.sv
// Periodically latches and clocks two NES pads sharing latch/clock lines,
// deserialises their buttons and feeds changes to the event arbiter.
module nes_poll_sequencer
  import nes_pkg::*;
#(
  parameter int CCLK_DIV    = 256,
  parameter int POLL_PERIOD = 262144
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_en,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       frame_done,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_pad,
  output logic [2:0] evt_code,
  output logic       evt_press
);

  localparam int TW = $clog2(POLL_PERIOD);
  localparam int CW = $clog2(2 * CCLK_DIV);

  logic [TW-1:0] timer;
  logic          poll_tick;
  poll_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift0;
  logic [7:0]    shift1;

  assign poll_tick = poll_en && (timer == TW'(POLL_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          timer <= '0;
    else if (!poll_en)  timer <= '0;
    else if (poll_tick) timer <= '0;
    else                timer <= timer + 1'b1;
  end

  // Ticks arriving outside IDLE are simply ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift0     <= 8'd0;
      shift1     <= 8'd0;
      buttons0   <= 8'd0;
      buttons1   <= 8'd0;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_tick) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            cnt       <= '0;
            bit_idx   <= 3'd0;
          end
        end
        LATCH: begin
          if (cnt == CW'(2 * CCLK_DIV - 1)) begin
            state     <= LOW;
            pad_latch <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt == CW'(CCLK_DIV - 1)) begin
            shift0[bit_idx] <= ~pad_data[0];
            shift1[bit_idx] <= ~pad_data[1];
            cnt             <= '0;
            if (bit_idx == 3'd7) begin
              state <= COMMIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              state   <= HIGH;
              pad_clk <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == CW'(CCLK_DIV - 1)) begin
            state   <= LOW;
            pad_clk <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          buttons0   <= shift0;
          buttons1   <= shift1;
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nes_event_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .buttons0  (buttons0),
    .buttons1  (buttons1),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pad   (evt_pad),
    .evt_code  (evt_code),
    .evt_press (evt_press)
  );

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Bench for nes_poll_sequencer: behavioural pads, expected-event queue and
// per-scenario tasks.
module tb_nes_poll_sequencer;
  import nes_pkg::*;

  localparam int CCLK_DIV    = 2;
  localparam int POLL_PERIOD = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic [1:0] pad_data;
  logic       pad_latch, pad_clk, frame_done;
  logic [7:0] buttons0, buttons1;
  logic       evt_valid, evt_pad, evt_press;
  logic [2:0] evt_code;

  logic [7:0] btn0 = 8'd0, btn1 = 8'd0;
  logic [7:0] sh0 = 8'd0, sh1 = 8'd0;
  logic       pclk_q = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_cyc_last = 0, acc_cyc_prev = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nes_poll_sequencer #(.CCLK_DIV(CCLK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
    .clk(clk), .reset(reset), .poll_en(poll_en), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons0(buttons0),
    .buttons1(buttons1), .frame_done(frame_done), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_pad(evt_pad), .evt_code(evt_code),
    .evt_press(evt_press)
  );

  // Behavioural 4021-style pads: parallel load while latched, shift on pad_clk rise.
  always @(posedge clk) begin
    pclk_q <= pad_clk;
    if (pad_latch) begin
      sh0 <= btn0;
      sh1 <= btn1;
    end else if (pad_clk && !pclk_q) begin
      sh0 <= {1'b0, sh0[7:1]};
      sh1 <= {1'b0, sh1[7:1]};
    end
  end
  assign pad_data = {~sh1[0], ~sh0[0]};

  function automatic logic [4:0] ev(input logic pad, input logic [2:0] code, input logic press);
    return {pad, code, press};
  endfunction

  task automatic push_diff(input logic [7:0] o0, input logic [7:0] n0,
                           input logic [7:0] o1, input logic [7:0] n1);
    for (int i = 0; i < 8; i++) if (o0[i] != n0[i]) exp_q.push_back(ev(1'b0, 3'(i), n0[i]));
    for (int i = 0; i < 8; i++) if (o1[i] != n1[i]) exp_q.push_back(ev(1'b1, 3'(i), n1[i]));
  endtask

  // Scoreboard: every transfer is checked against the head of the queue.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      logic [4:0] got, want;
      got = {evt_pad, evt_code, evt_press};
      vectors++;
      acc_cnt++;
      acc_cyc_prev = acc_cyc_last;
      acc_cyc_last = cyc;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL evt_unexpected got=%b want=<none>", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL evt_payload got=%b want=%b", got, want);
        end
      end
    end
  end

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 200);
    vectors++;
    if (!frame_done) begin
      miscompares++;
      $display("FAIL %s frame_done got=timeout want=pulse", tag);
    end
  endtask

  task automatic wait_latch(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!pad_latch && n < 200);
    vectors++;
    if (!pad_latch) begin
      miscompares++;
      $display("FAIL %s pad_latch got=timeout want=rise", tag);
    end
  endtask

  task automatic check_queue_empty(input string tag);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s pending_events got=%0d want=0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pad_latch, pad_clk, frame_done, evt_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=0000", {pad_latch, pad_clk, frame_done, evt_valid});
    end
    vectors++;
    if ({buttons0, buttons1} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_buttons got=%h want=0000", {buttons0, buttons1});
    end
    vectors++;
    if ({evt_pad, evt_code, evt_press} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_evt got=%b want=00000", {evt_pad, evt_code, evt_press});
    end
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic test_timing();
    logic el, ec, ef;
    evt_ready = 1'b1;
    @(posedge clk); #2 poll_en = 1'b1;
    wait_latch("timing");
    for (int c = 1; c <= 38; c++) begin
      el = (c >= 1 && c <= 4);
      ec = (c >= 5 && c <= 32 && ((c - 5) % 4) >= 2);
      ef = (c == 36);
      vectors++;
      if ({pad_latch, pad_clk, frame_done, evt_valid} !== {el, ec, ef, 1'b0}) begin
        miscompares++;
        $display("FAIL timing_c%0d got=%b want=%b", c,
                 {pad_latch, pad_clk, frame_done, evt_valid}, {el, ec, ef, 1'b0});
      end
      if (c == 36) begin
        vectors++;
        if ({buttons0, buttons1} !== 16'h0000) begin
          miscompares++;
          $display("FAIL timing_buttons got=%h want=0000", {buttons0, buttons1});
        end
      end
      if (c < 38) @(negedge clk);
    end
  endtask

  task automatic test_press();
    int n;
    evt_ready = 1'b0;
    btn0 = 8'h01;
    exp_q.push_back(ev(1'b0, 3'd0, 1'b1));
    wait_frame("press");
    vectors++;
    if ({buttons0, buttons1} !== 16'h0100) begin
      miscompares++;
      $display("FAIL press_buttons got=%h want=0100", {buttons0, buttons1});
    end
    n = 0;
    while (!evt_valid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({evt_valid, evt_pad, evt_code, evt_press} !== 6'b1_0_000_1) begin
        miscompares++;
        $display("FAIL press_hold%0d got=%b want=100001", i,
                 {evt_valid, evt_pad, evt_code, evt_press});
      end
      @(negedge clk);
    end
    @(posedge clk); #2 evt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL press_drop got=%b want=0", evt_valid);
    end
    check_queue_empty("press");
  endtask

  task automatic test_arbitration();
    int base, n;
    push_diff(btn0, 8'h00, btn1, btn1);
    btn0 = 8'h00;
    wait_frame("arb_clear");
    repeat (10) @(negedge clk);
    push_diff(btn0, 8'h08, btn1, 8'h02);
    btn0 = 8'h08;
    btn1 = 8'h02;
    base = acc_cnt;
    wait_frame("arb");
    n = 0;
    while (acc_cnt < base + 2 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (acc_cnt != base + 2 || (acc_cyc_last - acc_cyc_prev) < 2) begin
      miscompares++;
      $display("FAIL arb_spacing got=%0d events gap %0d want=2 events gap>=2",
               acc_cnt - base, acc_cyc_last - acc_cyc_prev);
    end
    check_queue_empty("arb");
  endtask

  task automatic test_release();
    push_diff(btn0, 8'h00, btn1, btn1);
    btn0 = 8'h00;
    wait_frame("release");
    repeat (10) @(negedge clk);
    vectors++;
    if ({dut.u_arb.reported0, dut.u_arb.reported1} !== 16'h0002) begin
      miscompares++;
      $display("FAIL release_reported got=%h want=0002",
               {dut.u_arb.reported0, dut.u_arb.reported1});
    end
    check_queue_empty("release");
  endtask

  task automatic test_coalesce();
    evt_ready = 1'b0;
    btn1 = 8'h00;
    exp_q.push_back(ev(1'b1, 3'd1, 1'b0));
    wait_frame("coal_n0");
    btn0 = 8'h01;
    wait_frame("coal_n1");
    vectors++;
    if ({buttons0, evt_valid, evt_pad, evt_code, evt_press} !== {8'h01, 6'b1_1_001_0}) begin
      miscompares++;
      $display("FAIL coal_held got=%h/%b want=01/110010", buttons0,
               {evt_valid, evt_pad, evt_code, evt_press});
    end
    btn0 = 8'h00;
    wait_frame("coal_n2");
    vectors++;
    if (buttons0 !== 8'h00) begin
      miscompares++;
      $display("FAIL coal_buttons got=%h want=00", buttons0);
    end
    @(posedge clk); #2 evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL coal_idle got=%b want=0", evt_valid);
    end
    check_queue_empty("coalesce");
  endtask

  task automatic test_revert();
    evt_ready = 1'b0;
    btn0 = 8'h04;
    exp_q.push_back(ev(1'b0, 3'd2, 1'b1));
    wait_frame("revert_press");
    btn0 = 8'h00;
    exp_q.push_back(ev(1'b0, 3'd2, 1'b0));
    wait_frame("revert_release");
    vectors++;
    if ({evt_valid, evt_pad, evt_code, evt_press} !== 6'b1_0_010_1) begin
      miscompares++;
      $display("FAIL revert_stable got=%b want=100101", {evt_valid, evt_pad, evt_code, evt_press});
    end
    @(posedge clk); #2 evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_queue_empty("revert");
  endtask

  task automatic test_reset_enable();
    int n, seen;
    push_diff(btn0, 8'hA5, btn1, btn1);
    btn0 = 8'hA5;
    wait_frame("rst_fill");
    vectors++;
    if (buttons0 !== 8'hA5) begin
      miscompares++;
      $display("FAIL rst_fill_buttons got=%h want=a5", buttons0);
    end
    wait_latch("rst_frame");
    repeat (12) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({pad_latch, pad_clk, buttons0, evt_valid, dut.u_arb.reported0} !== 19'd0) begin
      miscompares++;
      $display("FAIL rst_abort got=%b/%b/%h/%b/%h want=0/0/00/0/00", pad_latch, pad_clk,
               buttons0, evt_valid, dut.u_arb.reported0);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    push_diff(8'h00, 8'hA5, 8'h00, btn1);
    n = 0;
    do begin @(negedge clk); n++; end while (!pad_latch && n < 100);
    vectors++;
    if (n != 65) begin
      miscompares++;
      $display("FAIL rst_restart got=%0d cycles want=65", n);
    end
    wait_frame("rst_refill");
    vectors++;
    if (buttons0 !== 8'hA5) begin
      miscompares++;
      $display("FAIL rst_refill_buttons got=%h want=a5", buttons0);
    end
    repeat (12) @(negedge clk);
    check_queue_empty("rst_refill");
    push_diff(btn0, 8'h24, btn1, btn1);
    btn0 = 8'h24;
    wait_latch("en_frame");
    repeat (10) @(posedge clk);
    #2 poll_en = 1'b0;
    wait_frame("en_finish");
    vectors++;
    if (buttons0 !== 8'h24) begin
      miscompares++;
      $display("FAIL en_buttons got=%h want=24", buttons0);
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_latch) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL en_stopped got=%0d latch cycles want=0", seen);
    end
    check_queue_empty("enable");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_press();
    test_arbitration();
    test_release();
    test_coalesce();
    test_revert();
    test_reset_enable();
    check_queue_empty("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
